// File: rtl/dram_read_mux_pkg.sv
// TauCfg: shared configuration for the tau array.
// Provides the array size, address/data widths and the cache line geometry
// used by every block sitting around Top_sd. Also carries the DRAM read mux
// credit limit and the tau tag type.
// No ports (package).

package TauCfg;

  localparam int N_TAU          = 4;
  localparam int GLOBAL_ADDR_BW = 32;
  localparam int DATA_BW        = 32;
  localparam int CACHE_SIZE     = 4;

  // Maximum number of memory reads the DRAM mux keeps in flight.
  localparam int DRAM_MAX_OUT   = 8;

  // Tag width needed to name one tau; never narrower than one bit.
  localparam int TAU_IDW        = (N_TAU > 1) ? $clog2(N_TAU) : 1;

  typedef logic [TAU_IDW-1:0] TauId_t;

endpackage

// File: rtl/dram_mux_rr_arb.sv
// dram_mux_rr_arb: round-robin arbiter with a rotating priority pointer.
// The grant goes to the first requester at or after the pointer (wrapping),
// and the pointer then moves to one past the winner, so a requester waits at
// most N grants. Shared by the DRAM read and write muxes.
// Ports:
//   clk   in  1  clock
//   rst_n in  1  asynchronous active-low reset (pointer -> 0)
//   req   in  N  request vector
//   en    in  1  grant enable; no grant and no pointer move when low
//   gnt   out N  one-hot grant (or zero)

module dram_mux_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;

  // Scan the requesters starting at the pointer; first hit wins.
  always_comb begin
    int  idx;
    logic found;
    gnt      = '0;
    ptr_next = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (en && !found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_next = (idx + 1 >= N) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/dram_read_mux.sv
// dram_read_mux: merges the per-tau DRAM read-address channels onto a single
// memory read port and steers the in-order read data back to the tau that
// issued each request.
// Each granted request has its tau tag pushed into a small order FIFO; the
// FIFO head selects which tau sees the next returned line. Credits
// (outstanding tags) bound the number of reads in flight to MAX_OUT.
// Optional build macro: DRAM_READ_MUX_PERF_EN adds saturating perf counters.
// Ports:
//   i_clk     in   1            clock
//   i_rst     in   1            asynchronous active-low reset
//   ra_rdys   in   N_TAU        per-tau read-address valid
//   ra_acks   out  N_TAU        per-tau read-address accept (one-hot/zero)
//   ra_addrs  in   N_TAU x GBW  per-tau read address
//   mra_rdy   out  1            memory read-address valid (registered)
//   mra_ack   in   1            memory read-address accept
//   mra_addr  out  GBW          memory read address (registered)
//   mra_id    out  IDW          tau tag of the request (registered)
//   mrd_rdy   in   1            memory read-data valid (in order)
//   mrd_ack   out  1            memory read-data accept
//   mrd_data  in   LINE_BW      memory read line
//   rd_rdys   out  N_TAU        per-tau read-data valid
//   rd_acks   in   N_TAU        per-tau read-data accept
//   rd_data   out  LINE_BW      read line, shared by all taus
//   perf_grants       out N_TAU x 32  grants per tau          (perf build)
//   perf_credit_stall out 32  requesting cycles with no credit (perf build)
//   perf_mem_stall    out 32  cycles memory held off a request (perf build)

module dram_read_mux #(
  parameter int N_TAU   = TauCfg::N_TAU,
  parameter int GBW     = TauCfg::GLOBAL_ADDR_BW,
  parameter int LINE_BW = TauCfg::CACHE_SIZE * TauCfg::DATA_BW,
  parameter int MAX_OUT = TauCfg::DRAM_MAX_OUT,
  parameter int IDW     = (N_TAU > 1) ? $clog2(N_TAU) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_TAU-1:0]          ra_rdys,
  output logic [N_TAU-1:0]          ra_acks,
  input  logic [N_TAU-1:0][GBW-1:0] ra_addrs,
  output logic                      mra_rdy,
  input  logic                      mra_ack,
  output logic [GBW-1:0]            mra_addr,
  output logic [IDW-1:0]            mra_id,
  input  logic                      mrd_rdy,
  output logic                      mrd_ack,
  input  logic [LINE_BW-1:0]        mrd_data,
  output logic [N_TAU-1:0]          rd_rdys,
  input  logic [N_TAU-1:0]          rd_acks,
  output logic [LINE_BW-1:0]        rd_data
`ifdef DRAM_READ_MUX_PERF_EN
  ,
  output logic [N_TAU-1:0][31:0]    perf_grants,
  output logic [31:0]               perf_credit_stall,
  output logic [31:0]               perf_mem_stall
`endif
);

  localparam int PW  = $clog2(MAX_OUT);
  localparam int OCW = PW + 1;
  localparam logic [OCW-1:0] FULL = OCW'(MAX_OUT);

  logic [IDW-1:0] fifo_mem [MAX_OUT];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [OCW-1:0] outstanding;
  logic           fifo_empty;
  logic [IDW-1:0] head;

  logic           can_issue;
  logic           arb_en;
  logic [N_TAU-1:0] gnt;
  logic           grant;
  logic [IDW-1:0] gnt_id;
  logic           pop;

  // The credit check uses the registered count only, so a pop in this cycle
  // cannot open a grant in the same cycle (no rd_acks -> ra_acks path).
  // Grants are also held off while reset is asserted.
  assign can_issue = (!mra_rdy || mra_ack) && (outstanding < FULL);
  assign arb_en    = can_issue && i_rst;

  dram_mux_rr_arb #(
    .N (N_TAU)
  ) u_arb (
    .clk   (i_clk),
    .rst_n (i_rst),
    .req   (ra_rdys),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign ra_acks = gnt;
  assign grant   = |gnt;

  always_comb begin
    gnt_id = '0;
    for (int t = 0; t < N_TAU; t++) begin
      if (gnt[t]) begin
        gnt_id = IDW'(t);
      end
    end
  end

  // One-entry output register for the memory request channel.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mra_rdy  <= 1'b0;
      mra_addr <= '0;
      mra_id   <= '0;
    end else if (grant) begin
      mra_rdy  <= 1'b1;
      mra_addr <= ra_addrs[gnt_id];
      mra_id   <= gnt_id;
    end else if (mra_ack) begin
      mra_rdy  <= 1'b0;
    end
  end

  // The outstanding count equals the FIFO occupancy, so it doubles as the
  // empty flag.
  assign fifo_empty = (outstanding == '0);
  assign head       = fifo_mem[rd_ptr];

  // Response steering is purely combinational: the head tag picks the tau.
  always_comb begin
    rd_rdys = '0;
    if (mrd_rdy && !fifo_empty) begin
      rd_rdys[head] = 1'b1;
    end
  end

  assign rd_data = mrd_data;
  assign mrd_ack = rd_rdys[head] && rd_acks[head];
  assign pop     = mrd_ack;

  // Order FIFO: tags go in at grant time, come out when a line is delivered.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      fifo_mem    <= '{default: '0};
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
    end else begin
      if (grant) begin
        fifo_mem[wr_ptr] <= gnt_id;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (grant && !pop) begin
        outstanding <= outstanding + 1'b1;
      end else if (pop && !grant) begin
        outstanding <= outstanding - 1'b1;
      end
    end
  end

  // Returned data with nothing outstanding means the memory side broke the
  // protocol; it is never acked.
  mrd_no_tag: assert property (@(posedge i_clk) disable iff (!i_rst)
                               !(mrd_rdy && fifo_empty));

`ifdef DRAM_READ_MUX_PERF_EN
  // Saturating event counters.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      perf_grants       <= '0;
      perf_credit_stall <= '0;
      perf_mem_stall    <= '0;
    end else begin
      for (int t = 0; t < N_TAU; t++) begin
        if (gnt[t] && (perf_grants[t] != '1)) begin
          perf_grants[t] <= perf_grants[t] + 32'd1;
        end
      end
      if ((|ra_rdys) && (outstanding == FULL) && (perf_credit_stall != '1)) begin
        perf_credit_stall <= perf_credit_stall + 32'd1;
      end
      if (mra_rdy && !mra_ack && (perf_mem_stall != '1)) begin
        perf_mem_stall <= perf_mem_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_read_mux.sv
// tb_dram_read_mux: directed testbench for dram_read_mux.
// Expected memory requests and expected per-tau read lines are queued when
// stimulus is issued; two monitors pop and compare on every handshake.
// Build with DRAM_READ_MUX_PERF_EN defined to also check the perf counters.

module tb_dram_read_mux;

  logic                clk;
  logic                rst_n;
  logic [3:0]          ra_rdys;
  logic [3:0]          ra_acks;
  logic [3:0][31:0]    ra_addrs;
  logic                mra_rdy;
  logic                mra_ack;
  logic [31:0]         mra_addr;
  logic [1:0]          mra_id;
  logic                mrd_rdy;
  logic                mrd_ack;
  logic [127:0]        mrd_data;
  logic [3:0]          rd_rdys;
  logic [3:0]          rd_acks;
  logic [127:0]        rd_data;
`ifdef DRAM_READ_MUX_PERF_EN
  logic [3:0][31:0]    perf_grants;
  logic [31:0]         perf_credit_stall;
  logic [31:0]         perf_mem_stall;
`endif

  typedef struct {
    logic [31:0] addr;
    int          id;
  } req_t;

  typedef struct {
    int           tau;
    logic [127:0] data;
  } rd_t;

  req_t expReqQ[$];
  rd_t  expRdQ[$];

  int total = 0;
  int bad   = 0;

  dram_read_mux dut (
    .i_clk    (clk),
    .i_rst    (rst_n),
    .ra_rdys  (ra_rdys),
    .ra_acks  (ra_acks),
    .ra_addrs (ra_addrs),
    .mra_rdy  (mra_rdy),
    .mra_ack  (mra_ack),
    .mra_addr (mra_addr),
    .mra_id   (mra_id),
    .mrd_rdy  (mrd_rdy),
    .mrd_ack  (mrd_ack),
    .mrd_data (mrd_data),
    .rd_rdys  (rd_rdys),
    .rd_acks  (rd_acks),
    .rd_data  (rd_data)
`ifdef DRAM_READ_MUX_PERF_EN
    ,
    .perf_grants       (perf_grants),
    .perf_credit_stall (perf_credit_stall),
    .perf_mem_stall    (perf_mem_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] got,
                             input logic [127:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] rdys, input logic [3:0] racks,
                               input logic mack, input logic mrdy,
                               input logic [127:0] data);
    ra_rdys  = rdys;
    rd_acks  = racks;
    mra_ack  = mack;
    mrd_rdy  = mrdy;
    mrd_data = data;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushReq(input logic [31:0] addr, input int id);
    req_t e;
    e.addr = addr;
    e.id   = id;
    expReqQ.push_back(e);
  endtask

  task automatic pushRd(input int tau, input logic [127:0] data);
    rd_t e;
    e.tau  = tau;
    e.data = data;
    expRdQ.push_back(e);
  endtask

  task automatic setDefaultAddrs();
    for (int t = 0; t < 4; t++) begin
      ra_addrs[t] = 32'h1000 + 32'(t);
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
    expReqQ.delete();
    expRdQ.delete();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // Memory request monitor.
  always @(negedge clk) begin
    req_t e;
    if (rst_n && mra_rdy && mra_ack) begin
      if (expReqQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL req_unexpected: got addr %0h id %0d, expected none",
                 mra_addr, mra_id);
      end else begin
        e = expReqQ.pop_front();
        checkOutput("mra_addr", mra_addr, e.addr);
        checkOutput("mra_id", mra_id, e.id);
      end
    end
  end

  // Read data monitor.
  always @(negedge clk) begin
    rd_t e;
    if (rst_n && mrd_rdy && mrd_ack) begin
      if (expRdQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL rd_unexpected: got rdys %b data %0h, expected none",
                 rd_rdys, rd_data);
      end else begin
        e = expRdQ.pop_front();
        checkOutput("rd_rdys", rd_rdys, 128'(1) << e.tau);
        checkOutput("rd_data", rd_data, e.data);
      end
    end
  end

  initial begin
    int ackCount;
    logic [31:0] grantSum;

    rst_n = 1'b0;
    setDefaultAddrs();
    applyStimulus(4'b0000, 4'b0000, 1'b0, 1'b0, '0);
    tick();
    tick();

    // Reset values.
    checkOutput("rst_mra_rdy", mra_rdy, 0);
    checkOutput("rst_mra_addr", mra_addr, 0);
    checkOutput("rst_mra_id", mra_id, 0);
    checkOutput("rst_ra_acks", ra_acks, 0);
    checkOutput("rst_rd_rdys", rd_rdys, 0);
    checkOutput("rst_mrd_ack", mrd_ack, 0);

    // Single request from tau2 and its return.
    applyReset();
    ra_addrs[2] = 32'h100;
    applyStimulus(4'b0100, 4'b0000, 1'b1, 1'b0, '0);
    #1;
    checkOutput("t1_ra_acks", ra_acks, 4'b0100);
    pushReq(32'h100, 2);
    tick();
    ra_rdys = 4'b0000;
    #1;
    checkOutput("t1_mra_rdy", mra_rdy, 1);
    checkOutput("t1_mra_addr", mra_addr, 32'h100);
    checkOutput("t1_mra_id", mra_id, 2);
    tick();
    applyStimulus(4'b0000, 4'b0100, 1'b1, 1'b1, 128'hAB);
    #1;
    checkOutput("t1_rd_rdys", rd_rdys, 4'b0100);
    checkOutput("t1_rd_data", rd_data, 128'hAB);
    checkOutput("t1_mrd_ack", mrd_ack, 1);
    pushRd(2, 128'hAB);
    tick();
    mrd_rdy = 1'b0;
    #1;
    checkOutput("t1_empty", dut.outstanding, 0);

    // All taus requesting: rotation 0,1,2,3 and in-order return.
    applyReset();
    setDefaultAddrs();
    applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, '0);
    for (int k = 0; k < 8; k++) begin
      #1;
      checkOutput("t2_ra_acks", ra_acks, 128'(1) << (k % 4));
      pushReq(32'h1000 + 32'(k % 4), k % 4);
      tick();
    end
    applyStimulus(4'b0000, 4'b1111, 1'b1, 1'b1, '0);
    for (int k = 0; k < 8; k++) begin
      mrd_data = 128'hD0 + 128'(k);
      #1;
      checkOutput("t2_rd_rdys", rd_rdys, 128'(1) << (k % 4));
      pushRd(k % 4, 128'hD0 + 128'(k));
      tick();
    end
    mrd_rdy = 1'b0;
    #1;
    checkOutput("t2_empty", dut.outstanding, 0);

    // Credit limit: only 8 grants until a line is delivered.
    applyReset();
    setDefaultAddrs();
    applyStimulus(4'b1111, 4'b0000, 1'b1, 1'b0, '0);
    ackCount = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (ra_acks != 4'b0000) begin
        ackCount++;
      end
      checkOutput("t3_ra_acks", ra_acks, (k < 8) ? (128'(1) << (k % 4)) : 128'(0));
      if (k < 8) begin
        pushReq(32'h1000 + 32'(k % 4), k % 4);
      end
      tick();
    end
    checkOutput("t3_ack_count", ackCount, 8);
    mrd_rdy  = 1'b1;
    rd_acks  = 4'b1111;
    mrd_data = 128'hEE;
    #1;
    checkOutput("t3_pop_rd_rdys", rd_rdys, 4'b0001);
    checkOutput("t3_no_same_cycle_grant", ra_acks, 4'b0000);
    pushRd(0, 128'hEE);
    tick();
    mrd_rdy = 1'b0;
    #1;
    checkOutput("t3_grant_after_pop", ra_acks, 4'b0001);
    pushReq(32'h1000, 0);
    tick();
    ra_rdys = 4'b0000;
    #1;
`ifdef DRAM_READ_MUX_PERF_EN
    grantSum = '0;
    for (int t = 0; t < 4; t++) begin
      grantSum = grantSum + perf_grants[t];
    end
    checkOutput("t6_grant_sum", grantSum, 9);
    checkOutput("t6_credit_stall", perf_credit_stall, 5);
`else
    grantSum = '0;
`endif
    tick();

    // Memory backpressure and read-data backpressure.
    applyReset();
    ra_addrs[1] = 32'h300;
    ra_addrs[3] = 32'h333;
    applyStimulus(4'b0010, 4'b0000, 1'b0, 1'b0, '0);
    #1;
    checkOutput("t4_ra_acks", ra_acks, 4'b0010);
    tick();
    ra_rdys = 4'b1000;
    for (int k = 0; k < 5; k++) begin
      #1;
      checkOutput("t4_hold_rdy", mra_rdy, 1);
      checkOutput("t4_hold_addr", mra_addr, 32'h300);
      checkOutput("t4_hold_id", mra_id, 1);
      checkOutput("t4_no_grant", ra_acks, 4'b0000);
      tick();
    end
    pushReq(32'h300, 1);
    mra_ack = 1'b1;
    #1;
    checkOutput("t4_release_grant", ra_acks, 4'b1000);
    pushReq(32'h333, 3);
    tick();
    ra_rdys = 4'b0000;
    #1;
    checkOutput("t4_next_id", mra_id, 3);
    tick();
    applyStimulus(4'b0000, 4'b0000, 1'b1, 1'b1, 128'h55);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput("t4_rd_rdys_held", rd_rdys, 4'b0010);
      checkOutput("t4_mrd_ack_low", mrd_ack, 0);
      checkOutput("t4_fifo_kept", dut.outstanding, 2);
      tick();
    end
    rd_acks = 4'b0010;
    #1;
    checkOutput("t4_mrd_ack", mrd_ack, 1);
    pushRd(1, 128'h55);
    tick();
    rd_acks  = 4'b1000;
    mrd_data = 128'h66;
    #1;
    checkOutput("t4_second_rd", rd_rdys, 4'b1000);
    pushRd(3, 128'h66);
    tick();
    mrd_rdy = 1'b0;
    rd_acks = 4'b0000;
    #1;
    checkOutput("t4_empty", dut.outstanding, 0);

    // Asynchronous reset with three tags in flight.
    applyReset();
    setDefaultAddrs();
    applyStimulus(4'b0111, 4'b0000, 1'b1, 1'b0, '0);
    #1;
    checkOutput("t5_g0", ra_acks, 4'b0001);
    pushReq(32'h1000, 0);
    tick();
    #1;
    checkOutput("t5_g1", ra_acks, 4'b0010);
    pushReq(32'h1001, 1);
    tick();
    #1;
    checkOutput("t5_g2", ra_acks, 4'b0100);
    tick();
    applyStimulus(4'b1000, 4'b0000, 1'b0, 1'b1, 128'h77);
    #1;
    checkOutput("t5_pre_id", mra_id, 2);
    checkOutput("t5_pre_out", dut.outstanding, 3);
    checkOutput("t5_pre_rd_rdys", rd_rdys, 4'b0001);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_mra_rdy", mra_rdy, 0);
    checkOutput("t5_mra_addr", mra_addr, 0);
    checkOutput("t5_mra_id", mra_id, 0);
    checkOutput("t5_rd_rdys", rd_rdys, 0);
    checkOutput("t5_mrd_ack", mrd_ack, 0);
    checkOutput("t5_ra_acks", ra_acks, 0);
    checkOutput("t5_outstanding", dut.outstanding, 0);
    checkOutput("t5_pointer", dut.u_arb.ptr, 0);
    mrd_rdy = 1'b0;
    expReqQ.delete();
    expRdQ.delete();
    tick();
    tick();
    rst_n   = 1'b1;
    mra_ack = 1'b1;
    ra_rdys = 4'b1001;
    #1;
    checkOutput("t5_ptr_restart", ra_acks, 4'b0001);
    pushReq(32'h1000, 0);
    tick();
    ra_rdys = 4'b0000;
    tick();
    tick();

    checkOutput("reqq_drained", expReqQ.size(), 0);
    checkOutput("rdq_drained", expRdQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dram_read_mux.md
Name: dram_read_mux

Overview:
- Sits directly downstream of the Top_sd DRAM read ports.
- Merges the N_TAU per-tau read-address channels (dramra) onto one external memory read port, tagging each request with its tau index.
- Routes in-order returned read data back to the originating tau's dramrd channel.
- Allows the top level to talk to a single memory controller instead of N_TAU independent responders.

Parameters:
- N_TAU, TauCfg::N_TAU: number of tau read channels.
- GBW, TauCfg::GLOBAL_ADDR_BW: address width.
- LINE_BW, TauCfg::CACHE_SIZE*TauCfg::DATA_BW: width of one returned line.
- MAX_OUT, 8: maximum outstanding memory reads; power of 2, at least 2.
- IDW, $clog2(N_TAU) (minimum 1): request tag width.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  asynchronous active-low reset
- ra_rdys  in  N_TAU  per-tau read-address valid
- ra_acks  out  N_TAU  per-tau read-address accept (one-hot or zero)
- ra_addrs  in  N_TAU x GBW  per-tau read address
- mra_rdy  out  1  memory read-address valid
- mra_ack  in  1  memory read-address accept
- mra_addr  out  GBW  memory read address
- mra_id  out  IDW  tau tag of the request
- mrd_rdy  in  1  memory read-data valid (in order)
- mrd_ack  out  1  memory read-data accept
- mrd_data  in  LINE_BW  memory read line
- rd_rdys  out  N_TAU  per-tau read-data valid
- rd_acks  in  N_TAU  per-tau read-data accept
- rd_data  out  LINE_BW  read line, shared by all taus

Behaviour:
- Handshake rule, all channels: a transfer happens in a cycle where rdy=1 and ack=1.
  - rdy, once raised, holds with stable payload until acked.
  - ack is never asserted without rdy.
- Reset (i_rst=0, async):
  - mra_rdy=0, mra_addr=0, mra_id=0.
  - Order FIFO empty; round-robin pointer=0.
  - All ra_acks=0, rd_rdys=0, mrd_ack=0.
  - Reset mid-operation discards all in-flight tags; memory-side state is the integrator's responsibility.
- Request path: mra_* is a one-entry output register, so mra_rdy, mra_addr and mra_id are registered.
  - can_issue = (!mra_rdy || mra_ack) && outstanding < MAX_OUT.
  - outstanding counts tags pushed into the order FIFO and not yet popped (popped when a data beat is delivered). It is clog2(MAX_OUT)+1 bits wide.
  - When can_issue and any ra_rdys bit is set, the round-robin arbiter picks grant g = first set bit at or after the pointer (wrapping).
  - ra_acks[g]=1 that cycle (combinational from ra_rdys and state).
  - Next edge: mra_rdy=1, mra_addr=ra_addrs[g], mra_id=g; tag g is pushed to the order FIFO; pointer becomes (g+1) mod N_TAU.
  - A tag is pushed at grant time, not at mra_ack, so outstanding includes the request held in the mra register.
  - If mra_ack and no new grant: mra_rdy becomes 0 next edge.
  - Throughput: 1 request per cycle while mra_ack is held high and credits remain.
- Response path: combinational, zero latency.
  - head = order FIFO head tag.
  - rd_rdys[head] = mrd_rdy && !fifo_empty; all other rd_rdys bits are 0.
  - rd_data = mrd_data.
  - mrd_ack = rd_acks[head] && rd_rdys[head].
  - On transfer: pop the FIFO, outstanding-1.
- mrd_rdy with an empty FIFO is a protocol error: it is never acked, and an assertion fires in simulation.
- Simultaneous grant and pop in the same cycle: outstanding is unchanged.
  - When outstanding==MAX_OUT, a pop in a cycle does NOT enable a grant in that same cycle. can_issue uses the registered count, which avoids a combinational path from rd_acks to ra_acks.
- FIFO pointers are clog2(MAX_OUT) bits and wrap naturally.
- Arbitration starvation bound: a requesting tau is granted within N_TAU grants.

Optional Feature:
- Macro DRAM_READ_MUX_PERF_EN.
- When defined, adds the following ports, all reset to 0 and saturating at all-ones:
  - perf_grants (out, N_TAU x 32): grants per tau.
  - perf_credit_stall (out, 32): cycles with any ra_rdys set while outstanding==MAX_OUT.
  - perf_mem_stall (out, 32): cycles with mra_rdy && !mra_ack.
- When undefined: ports and counters are absent; functional behaviour is identical.

Decomposition:
- Taken from the shared package TauCfg: N_TAU, GLOBAL_ADDR_BW, DATA_BW, CACHE_SIZE.
- New additions to TauCfg: DRAM_MAX_OUT=8 and the typedef TauId_t = logic [IDW-1:0].
- One sub-module: dram_mux_rr_arb.
  - Inputs: request vector, enable. Output: one-hot grant.
  - Owns the rotating pointer register (same async active-low reset).
  - Reusable for the write channel mux.
- The order FIFO is inline; it is a small register array.

Test Plan:
1. After reset, tau2 requests addr 0x100, mra_ack=1 → ra_acks=0b0100 in the same cycle; mra_rdy=1, addr 0x100, id 2 next cycle. mrd_rdy with data 0xAB → rd_rdys=0b0100, rd_data=0xAB, FIFO then empty.
2. All 4 taus request continuously, mra_ack=1 → grant order 0,1,2,3,0,… (one per cycle); returned data delivered in the same tau order.
3. Credit full: MAX_OUT=8, mrd_rdy=0, 10 requests → exactly 8 ra_acks, then ra_acks=0 while rdys are held. After one data pop, the next grant occurs one cycle later.
4. Backpressure: mra_ack=0 for 5 cycles → mra_rdy, mra_addr and mra_id are stable and no further grants occur. Head tau rd_acks=0 → mrd_ack=0 and the FIFO is unchanged.
5. Async reset asserted with 3 outstanding tags → all outputs return to reset values immediately, outstanding=0, pointer=0.
6. With DRAM_READ_MUX_PERF_EN, run scenario 3 → perf_grants sum is 9 and perf_credit_stall matches the counted full cycles.
